// File: rtl/ap_perf_pkg.sv
// ap_perf_pkg: shared FSM/statistic encodings and saturating increment helper for the perf monitor
package ap_perf_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    WAIT_CONT = 2'd2
  } ch_state_e;
  typedef enum logic [2:0] {
    SEL_TXN      = 3'd0,
    SEL_LAST_LAT = 3'd1,
    SEL_MIN_LAT  = 3'd2,
    SEL_MAX_LAT  = 3'd3,
    SEL_STALL    = 3'd4,
    SEL_ITER     = 3'd5,
    SEL_STATE    = 3'd6
  } stat_sel_e;
  // Counters up to 64 bits wide share this helper; the value sticks at the w-bit all-ones maximum.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] m;
    m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= m) ? m : v + 64'd1;
  endfunction
endpackage

// File: rtl/ap_chan_stats.sv
// ap_chan_stats: start/done handshake FSM and saturating statistics for one monitored channel
module ap_chan_stats
  import ap_perf_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             upd,
  input  logic             clr,
  input  logic             ap_start,
  input  logic             ap_done,
  input  logic             ap_continue,
  input  logic             iter_enable,
  input  logic             iter_block,
  output logic [CNT_W-1:0] txn,
  output logic [CNT_W-1:0] last_lat,
  output logic [CNT_W-1:0] min_lat,
  output logic [CNT_W-1:0] max_lat,
  output logic [CNT_W-1:0] stall,
  output logic [CNT_W-1:0] iter,
  output ch_state_e        state,
  output logic             busy
);
  logic [CNT_W-1:0] lat_cnt, cur_lat;
  logic done_now, lat_step;
  ch_state_e next_state, done_state;

  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
    return CNT_W'(sat_inc(64'(v), CNT_W));
  endfunction

  // cur_lat is the latency including the current cycle; an accepting IDLE cycle counts as 1
  always_comb begin
    done_state = ap_continue ? IDLE : WAIT_CONT;
    done_now   = ap_done && ((state == IDLE && ap_start) || state == RUN);
    lat_step   = state == RUN || (state == IDLE && ap_start);
    cur_lat    = state == IDLE ? CNT_W'(1) : inc(lat_cnt);
    next_state = state == IDLE ? (ap_start ? (ap_done ? done_state : RUN) : IDLE)
               : state == RUN  ? (ap_done ? done_state : RUN)
               : (ap_continue ? IDLE : WAIT_CONT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      lat_cnt  <= '0;
      txn      <= '0;
      last_lat <= '0;
      min_lat  <= '1;
      max_lat  <= '0;
      stall    <= '0;
      iter     <= '0;
    end else begin
      state <= next_state;
      busy  <= next_state != IDLE;
      if (lat_step) lat_cnt <= cur_lat;
      if (clr) begin
        txn      <= '0;
        last_lat <= '0;
        min_lat  <= '1;
        max_lat  <= '0;
        stall    <= '0;
        iter     <= '0;
      end else if (upd) begin
        if (done_now) begin
          txn      <= inc(txn);
          last_lat <= cur_lat;
          if (cur_lat > max_lat) max_lat <= cur_lat;
          if (cur_lat < min_lat) min_lat <= cur_lat;
        end
        if (state == WAIT_CONT && !ap_continue) stall <= inc(stall);
        if (iter_enable && !iter_block && state != IDLE) iter <= inc(iter);
      end
    end
  end
endmodule

// File: rtl/ap_ctrl_perf_monitor.sv
// ap_ctrl_perf_monitor: multi-channel ap_ctrl handshake performance monitor with registered read port
module ap_ctrl_perf_monitor
  import ap_perf_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 32,
  parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             finish,
  input  logic [N_CH-1:0]  ap_start,
  input  logic [N_CH-1:0]  ap_done,
  input  logic [N_CH-1:0]  ap_continue,
  input  logic [N_CH-1:0]  iter_enable,
  input  logic [N_CH-1:0]  iter_block,
  input  logic [CH_W-1:0]  rd_ch,
  input  logic [2:0]       rd_sel,
  output logic [CNT_W-1:0] rd_data,
  output logic [N_CH-1:0]  busy,
  output logic             all_idle
);
  logic freeze;
  logic [CNT_W-1:0] rd_val;
  logic [CNT_W-1:0] txn [N_CH];
  logic [CNT_W-1:0] last_lat [N_CH];
  logic [CNT_W-1:0] min_lat [N_CH];
  logic [CNT_W-1:0] max_lat [N_CH];
  logic [CNT_W-1:0] stall [N_CH];
  logic [CNT_W-1:0] iter [N_CH];
  ch_state_e state [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ap_chan_stats #(.CNT_W(CNT_W)) u_ch (
      .clock       (clock),
      .reset       (reset),
      .upd         (enable && !freeze),
      .clr         (clear),
      .ap_start    (ap_start[i]),
      .ap_done     (ap_done[i]),
      .ap_continue (ap_continue[i]),
      .iter_enable (iter_enable[i]),
      .iter_block  (iter_block[i]),
      .txn         (txn[i]),
      .last_lat    (last_lat[i]),
      .min_lat     (min_lat[i]),
      .max_lat     (max_lat[i]),
      .stall       (stall[i]),
      .iter        (iter[i]),
      .state       (state[i]),
      .busy        (busy[i])
    );
  end

  assign all_idle = ~|busy;

  always_comb begin
    rd_val = '0;
    if (int'(rd_ch) < N_CH) begin
      case (rd_sel)
        SEL_TXN:      rd_val = txn[rd_ch];
        SEL_LAST_LAT: rd_val = last_lat[rd_ch];
        SEL_MIN_LAT:  rd_val = min_lat[rd_ch];
        SEL_MAX_LAT:  rd_val = max_lat[rd_ch];
        SEL_STALL:    rd_val = stall[rd_ch];
        SEL_ITER:     rd_val = iter[rd_ch];
        SEL_STATE:    rd_val = CNT_W'(state[rd_ch]);
        default:      rd_val = '0;
      endcase
    end
  end

  // freeze takes effect the cycle after finish, so events in the finish cycle still count
  always_ff @(posedge clock) begin
    if (reset) begin
      freeze  <= 1'b0;
      rd_data <= '0;
    end else begin
      freeze  <= freeze | finish;
      rd_data <= rd_val;
    end
  end
endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// tb_ap_ctrl_perf_monitor: directed scoreboard bench for a 32-bit and a 4-bit counter instance
module tb_ap_ctrl_perf_monitor;
  import ap_perf_pkg::*;
  typedef enum int {K_RD, K_RD4, K_BUSY, K_IDLE} kind_e;
  typedef struct {
    kind_e       kind;
    longint      due;
    logic [31:0] exp;
    string       name;
  } chk_t;
  chk_t q[$];
  logic clock = 0, reset = 1, enable = 1, clear = 0, finish = 0;
  logic [3:0] ap_start = '0, ap_done = '0, ap_continue = '1, iter_enable = '0, iter_block = '0;
  logic [1:0] rd_ch = '0;
  logic [2:0] rd_sel = '0;
  logic [31:0] rd_data;
  logic [3:0] rd_data4, busy, busy4;
  logic all_idle, all_idle4;
  int checks = 0, errors = 0;
  longint cyc = 0;

  ap_ctrl_perf_monitor #(.N_CH(4), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear), .finish(finish),
    .ap_start(ap_start), .ap_done(ap_done), .ap_continue(ap_continue),
    .iter_enable(iter_enable), .iter_block(iter_block), .rd_ch(rd_ch), .rd_sel(rd_sel),
    .rd_data(rd_data), .busy(busy), .all_idle(all_idle)
  );
  ap_ctrl_perf_monitor #(.N_CH(4), .CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear), .finish(finish),
    .ap_start(ap_start), .ap_done(ap_done), .ap_continue(ap_continue),
    .iter_enable(iter_enable), .iter_block(iter_block), .rd_ch(rd_ch), .rd_sel(rd_sel),
    .rd_data(rd_data4), .busy(busy4), .all_idle(all_idle4)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin : monitor
    logic [31:0] act;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].due <= cyc) begin
        act = q[i].kind == K_RD  ? rd_data
            : q[i].kind == K_RD4 ? 32'(rd_data4)
            : q[i].kind == K_BUSY ? 32'({busy4, busy})
            : 32'({all_idle4, all_idle});
        checks++;
        if (act !== q[i].exp) begin
          errors++;
          $display("FAIL %s: got %0h expected %0h (cycle %0d)", q[i].name, act, q[i].exp, cyc);
        end
        q.delete(i);
      end
    end
  end

  initial begin : watchdog
    repeat (5000) @(posedge clock);
    checks++;
    errors++;
    $display("FAIL timeout: simulation did not finish within 5000 cycles");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_busy(logic [3:0] b, string n);
    q.push_back('{K_BUSY, cyc, 32'({b, b}), n});
  endtask

  task automatic expect_idle(logic i, string n);
    q.push_back('{K_IDLE, cyc, 32'({i, i}), n});
  endtask

  task automatic rd(kind_e k, logic [1:0] ch, logic [2:0] sel, logic [31:0] e, string n);
    rd_ch = ch;
    rd_sel = sel;
    q.push_back('{k, cyc + 1, e, n});
    tick();
  endtask

  initial begin
    repeat (2) tick();
    reset = 0;
    checks++;
    if (busy !== 4'b0000 || all_idle !== 1'b1 || rd_data !== 32'd0 ||
        busy4 !== 4'b0000 || all_idle4 !== 1'b1 || rd_data4 !== 4'd0) begin
      errors++;
      $display("FAIL rst_state: busy=%b all_idle=%b rd_data=%0h busy4=%b all_idle4=%b rd_data4=%0h",
               busy, all_idle, rd_data, busy4, all_idle4, rd_data4);
    end
    q.push_back('{K_RD, cyc, 32'd0, "rst_rd_data"});
    expect_busy(4'b0000, "rst_busy");
    expect_idle(1'b1, "rst_all_idle");
    rd(K_RD, 0, SEL_TXN, 0, "rst_txn");
    rd(K_RD, 0, SEL_MIN_LAT, 32'hFFFF_FFFF, "rst_min");
    rd(K_RD4, 1, SEL_MIN_LAT, 32'hF, "rst_min4");
    ap_start[0] = 1; tick(); ap_start[0] = 0;
    expect_busy(4'b0001, "t1_busy_run");
    repeat (3) tick();
    ap_done[0] = 1; tick(); ap_done[0] = 0;
    expect_busy(4'b0000, "t1_busy_c5");
    expect_idle(1'b1, "t1_all_idle");
    rd(K_RD, 0, SEL_TXN, 1, "t1_txn");
    rd(K_RD, 0, SEL_LAST_LAT, 5, "t1_last");
    rd(K_RD, 0, SEL_MIN_LAT, 5, "t1_min");
    rd(K_RD, 0, SEL_MAX_LAT, 5, "t1_max");
    rd(K_RD, 0, SEL_STALL, 0, "t1_stall");
    ap_start[1] = 1;
    repeat (10) begin
      tick(); tick();
      ap_done[1] = 1; tick(); ap_done[1] = 0;
    end
    ap_start[1] = 0;
    rd(K_RD, 1, SEL_TXN, 10, "t2_txn");
    rd(K_RD, 1, SEL_MIN_LAT, 3, "t2_min");
    rd(K_RD, 1, SEL_MAX_LAT, 3, "t2_max");
    ap_start[2] = 1; tick(); ap_start[2] = 0;
    repeat (5) tick();
    ap_done[2] = 1; ap_continue[2] = 0; tick(); ap_done[2] = 0;
    repeat (4) rd(K_RD, 2, SEL_STATE, 2, "t3_state_wait");
    ap_continue[2] = 1;
    rd(K_RD, 2, SEL_STATE, 2, "t3_state_c11");
    expect_busy(4'b0000, "t3_busy_after");
    rd(K_RD, 2, SEL_STALL, 4, "t3_stall");
    rd(K_RD, 2, SEL_LAST_LAT, 7, "t3_last");
    rd(K_RD, 2, SEL_STATE, 0, "t3_state_idle");
    ap_start[3] = 1; ap_done[3] = 1; tick(); ap_start[3] = 0; ap_done[3] = 0;
    expect_busy(4'b0000, "t4_comb_busy");
    rd(K_RD, 3, SEL_LAST_LAT, 1, "t4_last1");
    rd(K_RD, 3, SEL_MIN_LAT, 1, "t4_min1");
    ap_start[3] = 1; tick(); ap_start[3] = 0;
    repeat (6) tick();
    ap_done[3] = 1; tick(); ap_done[3] = 0;
    rd(K_RD, 3, SEL_MAX_LAT, 8, "t4_max");
    rd(K_RD, 3, SEL_MIN_LAT, 1, "t4_min");
    rd(K_RD, 3, SEL_LAST_LAT, 8, "t4_last");
    rd(K_RD, 3, SEL_TXN, 2, "t4_txn");
    iter_enable[0] = 1; ap_start[0] = 1; tick(); ap_start[0] = 0;
    repeat (4) tick();
    iter_block[0] = 1; repeat (2) tick(); iter_block[0] = 0;
    repeat (12) tick();
    ap_done[0] = 1; tick(); ap_done[0] = 0;
    tick(); iter_enable[0] = 0;
    rd(K_RD4, 0, SEL_ITER, 15, "t5_iter_sat");
    rd(K_RD4, 0, SEL_LAST_LAT, 15, "t5_last_sat");
    rd(K_RD4, 0, SEL_MIN_LAT, 5, "t5_min4");
    rd(K_RD4, 0, SEL_TXN, 2, "t5_txn4");
    rd(K_RD, 0, SEL_ITER, 17, "t5_iter32");
    rd(K_RD, 0, SEL_LAST_LAT, 20, "t5_last32");
    rd(K_RD, 0, SEL_MAX_LAT, 20, "t5_max32");
    rd(K_RD, 0, 3'd7, 0, "t5_bad_sel");
    enable = 0; ap_start[1] = 1; ap_done[1] = 1; tick();
    ap_start[1] = 0; ap_done[1] = 0; enable = 1;
    expect_busy(4'b0000, "t6_en_busy");
    rd(K_RD, 1, SEL_TXN, 10, "t6_enable_hold");
    ap_start[0] = 1; tick(); ap_start[0] = 0;
    repeat (2) tick();
    clear = 1; tick(); clear = 0;
    tick();
    ap_done[0] = 1; tick(); ap_done[0] = 0;
    rd(K_RD, 0, SEL_TXN, 1, "t6_clr_txn");
    rd(K_RD, 0, SEL_LAST_LAT, 6, "t6_clr_last");
    rd(K_RD, 0, SEL_MIN_LAT, 6, "t6_clr_min");
    rd(K_RD, 0, SEL_ITER, 0, "t6_clr_iter");
    rd(K_RD, 1, SEL_TXN, 0, "t6_clr_txn1");
    rd(K_RD, 1, SEL_MIN_LAT, 32'hFFFF_FFFF, "t6_clr_min1");
    finish = 1; ap_start[3] = 1; ap_done[3] = 1; tick();
    finish = 0; ap_start[3] = 0; ap_done[3] = 0;
    ap_start[0] = 1; tick(); ap_start[0] = 0;
    ap_done[0] = 1; tick(); ap_done[0] = 0;
    ap_start[3] = 1; ap_done[3] = 1; tick(); ap_start[3] = 0; ap_done[3] = 0;
    rd(K_RD, 3, SEL_TXN, 1, "t6_finish_edge");
    rd(K_RD, 0, SEL_TXN, 1, "t6_frozen_txn");
    rd(K_RD, 0, SEL_LAST_LAT, 6, "t6_frozen_last");
    ap_start[0] = 1; tick(); ap_start[0] = 0;
    tick();
    expect_busy(4'b0001, "t6_busy_pre_rst");
    reset = 1; tick(); reset = 0;
    expect_busy(4'b0000, "t6_busy_post_rst");
    expect_idle(1'b1, "t6_idle_post_rst");
    rd(K_RD, 0, SEL_TXN, 0, "t6_rst_txn");
    rd(K_RD, 0, SEL_MIN_LAT, 32'hFFFF_FFFF, "t6_rst_min");
    ap_done[0] = 1; tick(); ap_done[0] = 0;
    rd(K_RD, 0, SEL_TXN, 0, "t6_stray_done");
    ap_start[2] = 1; ap_done[2] = 1; tick(); ap_start[2] = 0; ap_done[2] = 0;
    rd(K_RD, 2, SEL_TXN, 1, "t6_unfrozen");
    repeat (3) tick();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending: %0d scheduled checks never executed", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
